if_stage: RTL and testbench

- Instruction-fetch stage of the RV32 core. It owns the program counter and drives the address into the combinational instruction ROM, which returns the instruction in the same cycle.
- It registers PC, PC+4 and the instruction into the IF/ID pipeline register for the decode stage.
- It accepts stall from hazard logic and redirects from branch/jump resolution.
- It flushes the wrong-path instruction on a redirect and keeps a retired-fetch counter.

---
 rtl/if_stage.sv | 81 ++++++++
 tb/tb_if_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// ROM and fills the IF/ID pipeline register. Redirects flush the wrong-path
// fetch; stalls freeze everything. Edge priority: redirect > stall > normal.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc_plus4,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;

    // 32-bit modulo increment; the top word wraps to zero silently.
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign advance   = !redirect_valid && !stall;

    // Program counter: redirect target (word-aligned) beats stall beats +4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_target[31:2], 2'b00};
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID register: a redirect squashes the instruction at pc into a bubble
    // while id_pc/id_pc_plus4 keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_inst     <= NOP_INST;
            id_valid    <= 1'b0;
        end else if (redirect_valid) begin
            id_inst     <= NOP_INST;
            id_valid    <= 1'b0;
        end else if (!stall) begin
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            id_inst     <= imem_inst;
            id_valid    <= 1'b1;
        end
    end

    // One-cycle flag for a redirect whose target had low address bits set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
        end
    end

    // Count every instruction latched into IF/ID; wraps modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (advance) begin
            fetch_count <= fetch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational ROM model.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0013),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr(imem_addr),
        .imem_inst(imem_inst),
        .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4),
        .id_inst(id_inst),
        .id_valid(id_valid),
        .misalign_err(misalign_err),
        .fetch_count(fetch_count)
    );

    // Bench ROM: three fixed words, everything else a recognisable pattern.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0045_0693;
            32'h0000_0004: rom = 32'h0010_0713;
            32'h0000_0008: rom = 32'h00b7_6463;
            default:       rom = 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    assign imem_inst = rom(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  imem_addr, 32'h0);
        check({tag, "_pc"},    id_pc, 32'h0);
        check({tag, "_pc4"},   id_pc_plus4, 32'h0);
        check({tag, "_inst"},  id_inst, NOP);
        check({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
        check({tag, "_mis"},   {31'b0, misalign_err}, 32'h0);
        check({tag, "_cnt"},   fetch_count, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;

        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Sequential fetch
        step();
        check("e1_pc", id_pc, 32'h0);
        check("e1_pc4", id_pc_plus4, 32'h4);
        check("e1_inst", id_inst, 32'h0045_0693);
        check("e1_valid", {31'b0, id_valid}, 32'h1);
        check("e1_addr", imem_addr, 32'h4);
        check("e1_cnt", fetch_count, 32'd1);
        step();
        check("e2_pc", id_pc, 32'h4);
        check("e2_pc4", id_pc_plus4, 32'h8);
        check("e2_inst", id_inst, 32'h0010_0713);
        check("e2_cnt", fetch_count, 32'd2);

        // Stall three cycles with pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", imem_addr, 32'h8);
            check("stall_pc", id_pc, 32'h4);
            check("stall_inst", id_inst, 32'h0010_0713);
            check("stall_valid", {31'b0, id_valid}, 32'h1);
            check("stall_cnt", fetch_count, 32'd2);
        end
        stall = 1'b0;
        step();
        check("unstall_pc", id_pc, 32'h8);
        check("unstall_inst", id_inst, 32'h00b7_6463);
        check("unstall_cnt", fetch_count, 32'd3);

        // Redirect to 0x30 (bubble, count holds)
        redirect_valid = 1'b1;
        redirect_target = 32'h30;
        step();
        check("rd30_addr", imem_addr, 32'h30);
        check("rd30_valid", {31'b0, id_valid}, 32'h0);
        check("rd30_pc_hold", id_pc, 32'h8);
        check("rd30_pc4_hold", id_pc_plus4, 32'hC);
        check("rd30_inst", id_inst, NOP);
        check("rd30_cnt", fetch_count, 32'd3);

        // Redirect wins over simultaneous stall
        stall = 1'b1;
        redirect_target = 32'h1c;
        step();
        check("rds_addr", imem_addr, 32'h1c);
        check("rds_inst", id_inst, NOP);
        check("rds_valid", {31'b0, id_valid}, 32'h0);
        check("rds_mis", {31'b0, misalign_err}, 32'h0);
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
        check("after_rds_pc", id_pc, 32'h1c);
        check("after_rds_pc4", id_pc_plus4, 32'h20);
        check("after_rds_inst", id_inst, 32'hC0DE_001C);
        check("after_rds_valid", {31'b0, id_valid}, 32'h1);
        check("after_rds_cnt", fetch_count, 32'd4);

        // Misaligned redirect: one-cycle pulse
        redirect_valid = 1'b1;
        redirect_target = 32'h46;
        step();
        check("mis_addr", imem_addr, 32'h44);
        check("mis_flag", {31'b0, misalign_err}, 32'h1);
        redirect_valid = 1'b0;
        step();
        check("mis_clear", {31'b0, misalign_err}, 32'h0);
        check("mis_pc", id_pc, 32'h44);
        check("mis_cnt", fetch_count, 32'd5);

        // Back-to-back redirects, second misaligned, then a stall edge
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        step();
        check("b2b1_addr", imem_addr, 32'h100);
        check("b2b1_valid", {31'b0, id_valid}, 32'h0);
        redirect_target = 32'h203;
        step();
        check("b2b2_addr", imem_addr, 32'h200);
        check("b2b2_mis", {31'b0, misalign_err}, 32'h1);
        redirect_valid = 1'b0;
        stall = 1'b1;
        step();
        check("b2b_stall_mis", {31'b0, misalign_err}, 32'h0);
        check("b2b_stall_valid", {31'b0, id_valid}, 32'h0);
        check("b2b_stall_addr", imem_addr, 32'h200);
        check("b2b_stall_cnt", fetch_count, 32'd5);
        stall = 1'b0;

        // Wrap at top of address space
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        check("wrap_rd_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step();
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", id_pc_plus4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_inst", id_inst, 32'h3F21_FFFC);
        check("wrap_cnt", fetch_count, 32'd6);

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_pc", id_pc, 32'h0);
        check("post_rst_inst", id_inst, 32'h0045_0693);
        check("post_rst_cnt", fetch_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
